// File: rtl/cpuc_sequencer_pkg.sv
// Shared types and field positions for the CPUC program sequencer.
// Instruction word layout (32 bits):
//   [31:30] opcode, [29:0] EXEC payload,
//   WAIT: [15:0] cycle count, LOOP: [20:16] target PC, [15:0] pass count.
package cpuc_sequencer_pkg;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 30;
    localparam int PAYLOAD_W = OPC_LSB;
    localparam int CNT_W     = 16;
    localparam int TGT_LSB   = 16;

    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_WAIT = 2'b01,
        OP_LOOP = 2'b10,
        OP_HALT = 2'b11
    } t_seq_op;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } t_seq_state;

    typedef struct packed {
        t_seq_op                op;
        logic [PAYLOAD_W-1:0]   payload;
    } t_seq_instr;

endpackage

// File: rtl/cpuc_sequencer_if.sv
// Control / program-load / issue bundle of the CPUC sequencer.
//   master: the controller side (drives start/abort/stall and program writes)
//   slave : the sequencer (drives issue outputs and status)
interface cpuc_sequencer_if #(
    parameter int PROGRAM_SIZE = 32,
    parameter int INSTR_WIDTH  = 32
);
    localparam int PC_W = $clog2(PROGRAM_SIZE);

    logic                   start;
    logic                   abort;
    logic                   stall;
    logic                   prg_wr_en;
    logic [PC_W-1:0]        prg_wr_addr;
    logic [INSTR_WIDTH-1:0] prg_wr_data;
    logic                   instr_valid;
    logic [INSTR_WIDTH-3:0] instr_payload;
    logic [PC_W-1:0]        instr_pc;
    logic                   busy;
    logic                   done;
    logic                   pc_ovf;
    logic                   wr_err;

    modport master (
        output start, abort, stall, prg_wr_en, prg_wr_addr, prg_wr_data,
        input  instr_valid, instr_payload, instr_pc, busy, done, pc_ovf, wr_err
    );

    modport slave (
        input  start, abort, stall, prg_wr_en, prg_wr_addr, prg_wr_data,
        output instr_valid, instr_payload, instr_pc, busy, done, pc_ovf, wr_err
    );

endinterface

// File: rtl/cpuc_sequencer_prog_mem.sv
// Instruction store: register array, one write port, one asynchronous read
// port. Contents are deliberately not reset (a program survives reset).
//   clk      : write clock
//   wr_en    : write strobe (already qualified by the sequencer)
//   wr_addr  : write address, wr_data: write word
//   rd_addr  : read address, rd_data: combinational read word
module cpuc_sequencer_prog_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpuc_sequencer.sv
// CPUC program sequencer: runs the instruction store from PC 0 on start,
// issuing EXEC payloads, handling WAIT delays, a one-level hardware loop and
// HALT / PC overflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpuc_sequencer_if slave (control, program load, issue, status)
module cpuc_sequencer
    import cpuc_sequencer_pkg::*;
#(
    parameter int PROGRAM_SIZE = 32,
    parameter int INSTR_WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cpuc_sequencer_if.slave bus
);

    localparam int              PC_W    = $clog2(PROGRAM_SIZE);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROGRAM_SIZE - 1);

    t_seq_state             state;
    logic [PC_W-1:0]        pc;
    logic [CNT_W-1:0]       wait_cnt;
    logic [CNT_W-1:0]       loop_cnt;
    logic                   loop_act;
    logic                   valid_q;
    logic [INSTR_WIDTH-3:0] payload_q;
    logic [PC_W-1:0]        instr_pc_q;
    logic                   done_q;
    logic                   pc_ovf_q;
    logic                   wr_err_q;

    logic [INSTR_WIDTH-1:0] rd_word;
    t_seq_instr             instr;
    logic [CNT_W-1:0]       fld_cnt;
    logic [PC_W-1:0]        fld_tgt;
    logic                   wr_ok;
    logic                   do_adv;
    logic                   do_jump;

    // Writes only land while idle; the same-cycle start still sees the new
    // word because RUN reads the store combinationally on the next cycle.
    assign wr_ok = bus.prg_wr_en && (state == ST_IDLE);

    cpuc_sequencer_prog_mem #(
        .DEPTH (PROGRAM_SIZE),
        .WIDTH (INSTR_WIDTH),
        .AW    (PC_W)
    ) u_prog_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (bus.prg_wr_addr),
        .wr_data (bus.prg_wr_data),
        .rd_addr (pc),
        .rd_data (rd_word)
    );

    // Field layout assumes a 32-bit instruction word.
    assign instr   = t_seq_instr'(rd_word);
    assign fld_cnt = instr.payload[CNT_W-1:0];
    assign fld_tgt = instr.payload[TGT_LSB +: PC_W];

    // Next-PC intent for the current cycle: step to PC+1, or branch to the
    // loop target. HALT and WAIT(n>0) do neither.
    always_comb begin
        do_adv  = 1'b0;
        do_jump = 1'b0;
        if (state == ST_RUN) begin
            case (instr.op)
                OP_EXEC: do_adv = 1'b1;
                OP_WAIT: do_adv = (fld_cnt == '0);
                OP_LOOP: begin
                    if (loop_act ? (loop_cnt == CNT_W'(1)) : (fld_cnt <= CNT_W'(1)))
                        do_adv = 1'b1;
                    else
                        do_jump = 1'b1;
                end
                default: ;
            endcase
        end else if (state == ST_WAIT) begin
            do_adv = (wait_cnt == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            wait_cnt   <= '0;
            loop_cnt   <= '0;
            loop_act   <= 1'b0;
            valid_q    <= 1'b0;
            payload_q  <= '0;
            instr_pc_q <= '0;
            done_q     <= 1'b0;
            pc_ovf_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_err_q <= bus.prg_wr_en && (state != ST_IDLE);

            if (bus.abort) begin
                state    <= ST_IDLE;
                valid_q  <= 1'b0;
                done_q   <= 1'b0;
                loop_act <= 1'b0;
            end else if (state == ST_IDLE) begin
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                if (bus.start) begin
                    state    <= ST_RUN;
                    pc       <= '0;
                    loop_act <= 1'b0;
                    pc_ovf_q <= 1'b0;
                end
            end else if (!bus.stall) begin
                valid_q <= 1'b0;
                done_q  <= 1'b0;

                // Stepping past the last entry never wraps: flag and finish.
                if (do_adv) begin
                    if (pc == PC_LAST) begin
                        pc_ovf_q <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        pc    <= pc + PC_W'(1);
                        state <= ST_RUN;
                    end
                end
                if (do_jump) pc <= fld_tgt;

                case (state)
                    ST_RUN: begin
                        case (instr.op)
                            OP_EXEC: begin
                                valid_q    <= 1'b1;
                                payload_q  <= instr.payload;
                                instr_pc_q <= pc;
                            end
                            OP_WAIT: begin
                                if (fld_cnt != '0) begin
                                    wait_cnt <= fld_cnt;
                                    state    <= ST_WAIT;
                                end
                            end
                            OP_LOOP: begin
                                // A nested LOOP reuses the active counter.
                                if (loop_act) begin
                                    if (loop_cnt == CNT_W'(1)) loop_act <= 1'b0;
                                    else                       loop_cnt <= loop_cnt - CNT_W'(1);
                                end else if (fld_cnt > CNT_W'(1)) begin
                                    loop_act <= 1'b1;
                                    loop_cnt <= fld_cnt - CNT_W'(1);
                                end
                            end
                            default: begin
                                done_q <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end
                    ST_WAIT: begin
                        if (wait_cnt != CNT_W'(1)) wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.instr_valid   = valid_q;
    assign bus.instr_payload = payload_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.pc_ovf        = pc_ovf_q;
    assign bus.wr_err        = wr_err_q;

endmodule

// File: tb/tb_cpuc_sequencer.sv
// Bench for cpuc_sequencer: a program-level model predicts, in unstalled
// cycles after start, when each EXEC appears and when Done fires; a negedge
// compare process checks the DUT against it each cycle of a run. Directed
// literal checks pin the model and cover abort, write-while-busy and reset.
module tb_cpuc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpuc_sequencer_if #(.PROGRAM_SIZE(32), .INSTR_WIDTH(32)) bus ();

    cpuc_sequencer #(.PROGRAM_SIZE(32), .INSTR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] prog [32];

    int          exp_t[$];
    logic [29:0] exp_pay[$];
    int          exp_pc[$];
    int          done_t;
    bit          exp_ovf;

    bit  mon_on = 0;
    int  tick, idx, cyc = 0, start_cyc, done_cyc;
    int  cons_q[$];

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] i_exec(input logic [29:0] p); return {2'b00, p}; endfunction
    function automatic logic [31:0] i_wait(input logic [15:0] n); return {2'b01, 14'd0, n}; endfunction
    function automatic logic [31:0] i_loop(input logic [4:0] t, input logic [15:0] c);
        return {2'b10, 9'd0, t, c};
    endfunction
    function automatic logic [31:0] i_halt(); return {2'b11, 30'd0}; endfunction

    // Walks the program: EXEC decoded at slot t is visible at t+1; every
    // instruction takes one decode slot except WAIT n>0, which takes n+1.
    // HALT or stepping past entry 31 gives Done at the following slot.
    function automatic void model_run();
        int t = 1, pc = 0, rem = 0, steps = 0;
        bit act = 0;
        logic [31:0] w;
        exp_t.delete(); exp_pay.delete(); exp_pc.delete();
        exp_ovf = 0;
        done_t = 0;
        while (1) begin
            int nxt;
            bit jump;
            w = prog[pc];
            nxt = t + 1;
            jump = 0;
            steps++;
            case (w[31:30])
                2'b00: begin
                    exp_t.push_back(t + 1);
                    exp_pay.push_back(w[29:0]);
                    exp_pc.push_back(pc);
                end
                2'b01: if (w[15:0] != 0) nxt = t + int'(w[15:0]) + 1;
                2'b10: begin
                    // rem = extra body passes still owed
                    if (!act) begin
                        if (w[15:0] > 1) begin act = 1; rem = int'(w[15:0]) - 1; jump = 1; end
                    end else if (rem > 1) begin
                        rem--; jump = 1;
                    end else begin
                        act = 0;
                    end
                end
                default: begin done_t = t + 1; return; end
            endcase
            if (jump) pc = int'(w[20:16]);
            else if (pc == 31) begin exp_ovf = 1; done_t = nxt; return; end
            else pc++;
            t = nxt;
            if (steps > 5000) begin done_t = t; return; end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            bit ev;
            ev = (idx < exp_t.size()) && (exp_t[idx] == tick);
            chk("busy", bus.busy, (tick >= 1 && tick <= done_t));
            chk("instr_valid", bus.instr_valid, ev);
            chk("done", bus.done, tick == done_t);
            if (ev) begin
                chk("instr_payload", bus.instr_payload, exp_pay[idx]);
                chk("instr_pc", bus.instr_pc, exp_pc[idx]);
            end
            if (tick >= 1) chk("pc_ovf", bus.pc_ovf, (tick >= done_t) ? exp_ovf : 1'b0);
            if (bus.instr_valid && !bus.stall) cons_q.push_back(cyc);
            if (bus.done) done_cyc = cyc;
            if (!bus.stall) begin
                if (ev) idx++;
                tick++;
            end
            if (tick > done_t + 1) mon_on = 0;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] w);
        prog[a] = w;
        bus.prg_wr_en = 1;
        bus.prg_wr_addr = 5'(a);
        bus.prg_wr_data = w;
        step();
        bus.prg_wr_en = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    // One monitored run. Stall is held for st_len cycles starting st_from
    // cycles after the start cycle; optionally a store write rides along
    // with the start pulse.
    task automatic run_prog(input int st_from, input int st_len,
                            input bit wr, input int wa, input logic [31:0] wd);
        if (wr) begin
            prog[wa] = wd;
            bus.prg_wr_en = 1;
            bus.prg_wr_addr = 5'(wa);
            bus.prg_wr_data = wd;
        end
        model_run();
        cons_q.delete();
        tick = 0;
        idx = 0;
        done_cyc = -1;
        start_cyc = cyc;
        bus.start = 1;
        mon_on = 1;
        step();
        bus.start = 0;
        bus.prg_wr_en = 0;
        for (int c = 1; c < 3000 && mon_on; c++) begin
            bus.stall = (c >= st_from) && (c < st_from + st_len);
            step();
        end
        bus.stall = 0;
        if (mon_on) begin
            chk("run_timeout", 1, 0);
            mon_on = 0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, bus.instr_valid, 0);
        chk({tag, "_payload"}, bus.instr_payload, 0);
        chk({tag, "_pc"}, bus.instr_pc, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pc_ovf"}, bus.pc_ovf, 0);
        chk({tag, "_wr_err"}, bus.wr_err, 0);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.stall = 0;
        bus.prg_wr_en = 0; bus.prg_wr_addr = '0; bus.prg_wr_data = '0;
        for (int i = 0; i < 32; i++) prog[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1;
        step();

        // Basic: two EXECs back to back, then HALT.
        load(0, i_exec(30'h11)); load(1, i_exec(30'h22)); load(2, i_halt());
        run_prog(0, 0, 0, 0, '0);
        chk("basic_issues", cons_q.size(), 2);
        chk("basic_first_lat", cons_q[0] - start_cyc, 2);
        chk("basic_b2b", cons_q[1] - cons_q[0], 1);
        chk("basic_done_lat", done_cyc - start_cyc, 4);
        chk("basic_busy_after", bus.busy, 0);

        // Loop counts 3, 0, 1.
        load(0, i_exec(30'hA)); load(1, i_loop(5'd0, 16'd3)); load(2, i_halt());
        run_prog(0, 0, 0, 0, '0);
        chk("loop3_issues", cons_q.size(), 3);
        load(1, i_loop(5'd0, 16'd0));
        run_prog(0, 0, 0, 0, '0);
        chk("loop0_issues", cons_q.size(), 1);
        load(1, i_loop(5'd0, 16'd1));
        run_prog(0, 0, 0, 0, '0);
        chk("loop1_issues", cons_q.size(), 1);

        // WAIT 4, unstalled and with 3 stalled cycles inside the wait.
        load(0, i_exec(30'h1)); load(1, i_wait(16'd4)); load(2, i_exec(30'h2)); load(3, i_halt());
        run_prog(0, 0, 0, 0, '0);
        chk("wait4_gap", cons_q[1] - cons_q[0], 6);
        run_prog(4, 3, 0, 0, '0);
        chk("wait4_stall_gap", cons_q[1] - cons_q[0], 9);

        // Stall held 5 cycles while an EXEC is presented.
        load(0, i_exec(30'h1)); load(1, i_exec(30'h2)); load(2, i_exec(30'h3)); load(3, i_halt());
        run_prog(3, 5, 0, 0, '0);
        chk("stall_issues", cons_q.size(), 3);
        chk("stall_gap", cons_q[1] - cons_q[0], 6);

        // Write and start in the same cycle: new word is executed.
        run_prog(0, 0, 1, 0, i_exec(30'h55));
        chk("wrstart_issues", cons_q.size(), 3);

        // Whole store EXEC: overflow, then a fresh start clears the flag.
        for (int i = 0; i < 32; i++) load(i, i_exec(30'(32'h100 + i)));
        run_prog(0, 0, 0, 0, '0);
        chk("ovf_issues", cons_q.size(), 32);
        chk("ovf_flag", bus.pc_ovf, 1);
        load(0, i_halt());
        run_prog(0, 0, 0, 0, '0);
        chk("ovf_cleared", bus.pc_ovf, 0);

        // Abort in the middle of a loop; a rerun must start the loop afresh.
        load(0, i_exec(30'hA)); load(1, i_loop(5'd0, 16'd100)); load(2, i_halt());
        pulse_start();
        repeat (6) step();
        bus.abort = 1;
        step();
        bus.abort = 0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.instr_valid, 0);
        chk("abort_done", bus.done, 0);
        run_prog(0, 0, 0, 0, '0);
        chk("abort_rerun_issues", cons_q.size(), 100);

        // Start and Abort together from idle: stays idle.
        bus.start = 1; bus.abort = 1;
        step();
        bus.start = 0; bus.abort = 0;
        chk("start_abort_busy", bus.busy, 0);

        // Write while busy: error pulse, store untouched.
        pulse_start();
        repeat (3) step();
        bus.prg_wr_en = 1; bus.prg_wr_addr = 5'd0; bus.prg_wr_data = i_halt();
        step();
        bus.prg_wr_en = 0;
        chk("wr_err_pulse", bus.wr_err, 1);
        step();
        chk("wr_err_clear", bus.wr_err, 0);
        bus.abort = 1;
        step();
        bus.abort = 0;
        run_prog(0, 0, 0, 0, '0);
        chk("wr_busy_store_kept", cons_q.size(), 100);

        // Asynchronous reset in the middle of a run.
        pulse_start();
        repeat (3) step();
        #2;
        rst_n = 0;
        #1;
        check_reset_values("midrst");
        step();
        rst_n = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
